// File: rtl/pea_pkg.sv
// Shared types and sizing helpers for the elastic processing element.
// Contents:
//   s_pe_op_t      - functional-unit operation encoding (3 bits)
//   delay_src_t    - source select for delay-line stage 0 (2 bits)
//   calc_log_n_in  - operand selector width for a given neighbour count
//   calc_cfg_w     - total config word width
package pea_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_MUL    = 3'd3,
    OP_MAX    = 3'd4,
    OP_MIN    = 3'd5,
    OP_ACC    = 3'd6,
    OP_PASS_A = 3'd7
  } s_pe_op_t;

  typedef enum logic [1:0] {
    DSRC_OP_A = 2'd0,
    DSRC_OP_B = 2'd1,
    DSRC_FU   = 2'd2,
    DSRC_ZERO = 2'd3
  } delay_src_t;

  // Operand sources are the neighbours plus SELF and CONST.
  function automatic int calc_log_n_in(input int n_neigh);
    return $clog2(n_neigh + 2);
  endfunction

  // Config word: sel_a, sel_b, op(3), delay_src(2), delay_tap.
  function automatic int calc_cfg_w(input int n_neigh, input int delay_depth);
    return 2 * calc_log_n_in(n_neigh) + 3 + 2 + $clog2(delay_depth);
  endfunction

endpackage

// File: rtl/s_pe_elastic_if.sv
// Result stream between the processing element and its consumer.
//   res_o   - FIFO head result (reads 0 while valid_o is low)
//   valid_o - FIFO non-empty
//   ready_i - consumer accepts res_o this cycle
// master: the producing PE.  slave: the consumer.
interface s_pe_elastic_if #(
  parameter int N_BITS = 32
);
  logic [N_BITS-1:0] res_o;
  logic              valid_o;
  logic              ready_i;

  modport master (output res_o, output valid_o, input ready_i);
  modport slave  (input res_o, input valid_o, output ready_i);
endinterface

// File: rtl/s_pe_out_fifo.sv
// Output result FIFO for the processing element.
// Ports:
//   clk_i, rst_n_i - clock, asynchronous active-low reset
//   push_i, data_i - write request and data
//   pop_i          - read request (head leaves the FIFO)
//   data_o         - head entry, forced to 0 while empty
//   full_o, empty_o
// A push while full is accepted only when a pop happens in the same cycle.
module s_pe_out_fifo #(
  parameter int N_BITS    = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [N_BITS-1:0] data_i,
  input  logic              pop_i,
  output logic [N_BITS-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(OUT_DEPTH);

  logic [N_BITS-1:0] mem [OUT_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/s_pe_elastic.sv
// Elastic processing element: selects two operands from neighbours, its own
// last result (SELF) or a constant, applies a configurable operation, and
// pushes results into a small output FIFO. An ACC mode sums op_b over a
// window of acc_len fires and pushes once per window. A delay line records
// a selectable value on every fire.
// Ports:
//   clk_i, rst_n_i  - clock, asynchronous active-low reset
//   ctrl_pe_i       - {delay_tap, delay_src, op, sel_b, sel_a}
//   const_i         - constant operand
//   acc_len_i       - accumulation window length (0 behaves as 1)
//   neigh_op_i      - neighbour operands
//   neigh_valid_i   - neighbour operand valids
//   fire_o          - operands consumed this cycle (combinational)
//   delay_op_o      - selected delay-line tap
//   delay_valid_o   - valid of selected tap
//   out_if          - result stream (res_o / valid_o / ready_i)
module s_pe_elastic
  import pea_pkg::*;
#(
  parameter int N_BITS      = 32,
  parameter int N_NEIGH     = 4,
  parameter int DELAY_DEPTH = 4,
  parameter int OUT_DEPTH   = 2,
  localparam int LOG_N_IN   = calc_log_n_in(N_NEIGH),
  localparam int CFG_W      = calc_cfg_w(N_NEIGH, DELAY_DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [CFG_W-1:0]               ctrl_pe_i,
  input  logic [N_BITS-1:0]              const_i,
  input  logic [15:0]                    acc_len_i,
  input  logic [N_NEIGH-1:0][N_BITS-1:0] neigh_op_i,
  input  logic [N_NEIGH-1:0]             neigh_valid_i,
  output logic                           fire_o,
  output logic [N_BITS-1:0]              delay_op_o,
  output logic                           delay_valid_o,
  s_pe_elastic_if.master                 out_if
);

  localparam int TAP_W = $clog2(DELAY_DEPTH);

  // Returns {valid, data}; selectors beyond CONST read as invalid.
  function automatic logic [N_BITS:0] pick_operand(
    input logic [LOG_N_IN-1:0]              sel,
    input logic [N_NEIGH-1:0][N_BITS-1:0]   nop,
    input logic [N_NEIGH-1:0]               nvld,
    input logic [N_BITS-1:0]                self_v,
    input logic [N_BITS-1:0]                const_v
  );
    logic [N_BITS:0] r;
    r = '0;
    for (int i = 0; i < N_NEIGH; i++)
      if (sel == LOG_N_IN'(i)) r = {nvld[i], nop[i]};
    if (sel == LOG_N_IN'(N_NEIGH))     r = {1'b1, self_v};
    if (sel == LOG_N_IN'(N_NEIGH + 1)) r = {1'b1, const_v};
    return r;
  endfunction

  logic [LOG_N_IN-1:0]        sel_a, sel_b;
  s_pe_op_t                   op, op_q;
  delay_src_t                 dsrc;
  logic [TAP_W-1:0]           tap;

  logic signed [N_BITS-1:0]   op_a, op_b, mul_lo, fu_res, acc_sum;
  logic signed [N_BITS-1:0]   self_q, acc_q;
  logic                       a_vld, b_vld;
  logic [15:0]                cnt_q, cnt_eff, acc_len_eff;
  logic                       op_chg, is_acc, acc_last, need_space;
  logic                       fire, push, pop;
  logic                       fifo_full, fifo_empty;
  logic [N_BITS-1:0]          fifo_head;

  logic [N_BITS-1:0]          dly_data [DELAY_DEPTH];
  logic [DELAY_DEPTH-1:0]     dly_vld;
  logic [N_BITS-1:0]          dly_in;

  assign sel_a = ctrl_pe_i[LOG_N_IN-1:0];
  assign sel_b = ctrl_pe_i[2*LOG_N_IN-1:LOG_N_IN];
  assign op    = s_pe_op_t'(ctrl_pe_i[2*LOG_N_IN+2 -: 3]);
  assign dsrc  = delay_src_t'(ctrl_pe_i[2*LOG_N_IN+4 -: 2]);
  assign tap   = ctrl_pe_i[CFG_W-1 -: TAP_W];

  assign {a_vld, op_a} = pick_operand(sel_a, neigh_op_i, neigh_valid_i, self_q, const_i);
  assign {b_vld, op_b} = pick_operand(sel_b, neigh_op_i, neigh_valid_i, self_q, const_i);

  // An op change this cycle makes the stored window stale; treat it as empty
  // so a fire in the same cycle already starts a fresh window.
  assign op_chg      = (op != op_q);
  assign cnt_eff     = op_chg ? 16'd0 : cnt_q;
  assign acc_len_eff = (acc_len_i == 16'd0) ? 16'd1 : acc_len_i;
  assign is_acc      = (op == OP_ACC);
  assign acc_last    = (cnt_eff == acc_len_eff - 16'd1);
  assign acc_sum     = (cnt_eff == 16'd0) ? op_b : acc_q + op_b;

  // Low half of a product is sign-agnostic, so a plain N-bit multiply suffices.
  assign mul_lo = op_a * op_b;

  always_comb begin
    fu_res = '0;
    case (op)
      OP_ADD:    fu_res = op_a + op_b;
      OP_SUB:    fu_res = op_a - op_b;
      OP_MUL:    fu_res = mul_lo;
      OP_MAX:    fu_res = (op_a > op_b) ? op_a : op_b;
      OP_MIN:    fu_res = (op_a < op_b) ? op_a : op_b;
      OP_ACC:    fu_res = acc_sum;
      OP_PASS_A: fu_res = op_a;
      default:   fu_res = '0;
    endcase
  end

  // Only fires that push need FIFO room; a pop this cycle frees one slot.
  assign need_space = !is_acc || acc_last;
  assign pop        = !fifo_empty && out_if.ready_i;
  assign fire       = (op != OP_NOP) && a_vld && b_vld &&
                      (!need_space || !fifo_full || pop);
  assign push       = fire && need_space;
  assign fire_o     = fire;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q   <= OP_NOP;
      cnt_q  <= '0;
      acc_q  <= '0;
      self_q <= '0;
    end else begin
      op_q <= op;
      if (push) self_q <= fu_res;
      if (op == OP_NOP) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (fire && is_acc) begin
        if (acc_last) begin
          cnt_q <= '0;
          acc_q <= '0;
        end else begin
          cnt_q <= cnt_eff + 16'd1;
          acc_q <= acc_sum;
        end
      end else if (op_chg) begin
        cnt_q <= '0;
        acc_q <= '0;
      end
    end
  end

  always_comb begin
    dly_in = '0;
    case (dsrc)
      DSRC_OP_A: dly_in = op_a;
      DSRC_OP_B: dly_in = op_b;
      DSRC_FU:   dly_in = fu_res;
      default:   dly_in = '0;
    endcase
  end

  // Delay line: advances one stage per fire, holds otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DELAY_DEPTH; i++) dly_data[i] <= '0;
      dly_vld <= '0;
    end else if (fire) begin
      dly_data[0] <= dly_in;
      for (int i = 1; i < DELAY_DEPTH; i++) dly_data[i] <= dly_data[i-1];
      dly_vld <= {dly_vld[DELAY_DEPTH-2:0], 1'b1};
    end
  end

  assign delay_op_o    = dly_data[tap];
  assign delay_valid_o = dly_vld[tap];

  s_pe_out_fifo #(
    .N_BITS    (N_BITS),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (fu_res),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_if.res_o   = fifo_head;
  assign out_if.valid_o = !fifo_empty;

endmodule

// File: tb/tb_s_pe_elastic.sv
// Directed bench for s_pe_elastic with N_BITS=32, N_NEIGH=4,
// DELAY_DEPTH=4, OUT_DEPTH=2. Selector 4 = SELF, 5 = CONST.
module tb_s_pe_elastic;

  localparam int CFG_W = pea_pkg::calc_cfg_w(4, 4);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [CFG_W-1:0]   ctrl;
  logic [31:0]        cst;
  logic [15:0]        acc_len;
  logic [3:0][31:0]   nop;
  logic [3:0]         nvld;
  logic               fire;
  logic [31:0]        dop;
  logic               dvld;
  int                 n_assert = 0;
  int                 n_fail   = 0;

  s_pe_elastic_if #(.N_BITS(32)) out_if ();

  s_pe_elastic #(
    .N_BITS      (32),
    .N_NEIGH     (4),
    .DELAY_DEPTH (4),
    .OUT_DEPTH   (2)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .ctrl_pe_i     (ctrl),
    .const_i       (cst),
    .acc_len_i     (acc_len),
    .neigh_op_i    (nop),
    .neigh_valid_i (nvld),
    .fire_o        (fire),
    .delay_op_o    (dop),
    .delay_valid_o (dvld),
    .out_if        (out_if)
  );

  always #5 clk = ~clk;

  function automatic logic [CFG_W-1:0] cfg(input int sa, input int sb, input int op,
                                           input int ds, input int tp);
    return {2'(tp), 2'(ds), 3'(op), 3'(sb), 3'(sa)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ctrl = '0; cst = '0; acc_len = '0; nop = '0; nvld = '0;
    out_if.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_if.valid_o, 0);
    chk("rst_res", out_if.res_o, 0);
    chk("rst_dvld", dvld, 0);
    chk("rst_dop", dop, 0);
    chk("rst_fire", fire, 0);
    #3 rst_n = 1'b1;
    tick;

    // ADD neigh0 + CONST
    ctrl = cfg(0, 5, 1, 0, 0); cst = 5; nop[0] = 10; nvld = 4'b0001; #1;
    chk("add_fire", fire, 1);
    chk("add_valid_pre", out_if.valid_o, 0);
    tick; nvld = '0; #1;
    chk("add_valid", out_if.valid_o, 1);
    chk("add_res", out_if.res_o, 15);
    chk("add_fire_off", fire, 0);
    tick;
    chk("add_popped", out_if.valid_o, 0);
    chk("add_res_zero", out_if.res_o, 0);

    // SELF + CONST
    ctrl = cfg(4, 5, 1, 0, 0); cst = 1; #1;
    chk("self_fire", fire, 1);
    tick; ctrl = cfg(0, 0, 0, 0, 0); #1;
    chk("self_res", out_if.res_o, 16);
    chk("nop_fire", fire, 0);
    tick;

    // out-of-range selector
    ctrl = cfg(6, 5, 1, 0, 0); #1;
    chk("oor_fire", fire, 0);

    // backpressure with full FIFO
    out_if.ready_i = 1'b0; ctrl = cfg(0, 5, 1, 0, 0); cst = 0; nop[0] = 100; nvld = 4'b0001; #1;
    chk("bp_fire0", fire, 1);
    tick; nop[0] = 101; #1;
    chk("bp_fire1", fire, 1);
    tick;
    chk("bp_full_fire", fire, 0);
    chk("bp_head", out_if.res_o, 100);
    tick;
    chk("bp_stall_fire", fire, 0);
    nop[0] = 102; out_if.ready_i = 1'b1; #1;
    chk("bp_pop_fire", fire, 1);
    tick; nvld = '0; out_if.ready_i = 1'b0; #1;
    chk("bp_head2", out_if.res_o, 101);
    chk("bp_valid2", out_if.valid_o, 1);
    tick;
    chk("bp_hold", out_if.res_o, 101);
    out_if.ready_i = 1'b1;
    tick;
    chk("bp_head3", out_if.res_o, 102);
    tick;
    chk("bp_drained", out_if.valid_o, 0);

    // ACC window of 4 on neigh1
    ctrl = cfg(5, 1, 6, 0, 0); acc_len = 4; nvld = 4'b0010;
    for (int v = 1; v <= 4; v++) begin
      nop[1] = v;
      tick;
      if (v < 4) chk("acc4_no_push", out_if.valid_o, 0);
    end
    nvld = '0;
    chk("acc4_valid", out_if.valid_o, 1);
    chk("acc4_res", out_if.res_o, 10);
    tick;
    chk("acc4_popped", out_if.valid_o, 0);

    // acc_len = 0 behaves as 1
    acc_len = 0; nvld = 4'b0010; nop[1] = 5;
    tick;
    chk("acc0_res_a", out_if.res_o, 5);
    nop[1] = 6;
    tick;
    chk("acc0_res_b", out_if.res_o, 6);
    nvld = '0;
    tick;
    chk("acc0_drained", out_if.valid_o, 0);

    // op change discards a partial window
    acc_len = 4; nvld = 4'b0010; nop[1] = 1;
    tick; nop[1] = 2;
    tick;
    chk("chg_partial", out_if.valid_o, 0);
    ctrl = cfg(5, 1, 1, 0, 0); nvld = '0;
    tick;
    ctrl = cfg(5, 1, 6, 0, 0); nvld = 4'b0010; nop[1] = 5;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i < 3) chk("chg_no_push", out_if.valid_o, 0);
    end
    nvld = '0;
    chk("chg_res", out_if.res_o, 20);
    tick;

    // delay line, op_a source, tap 2
    ctrl = cfg(0, 5, 1, 0, 2); cst = 0; nvld = 4'b0001;
    nop[0] = 7;  tick;
    nop[0] = 8;  tick;
    nop[0] = 9;  tick;
    nvld = '0;
    chk("dly_op", dop, 7);
    chk("dly_vld", dvld, 1);
    tick; tick;
    chk("dly_stall", dop, 7);
    nvld = 4'b0001; nop[0] = 10;
    tick; nvld = '0;
    chk("dly_shift", dop, 8);
    ctrl = cfg(0, 5, 1, 0, 0); #1;
    chk("dly_tap0", dop, 10);
    tick;

    // arithmetic corner cases
    nvld = 4'b0011;
    ctrl = cfg(0, 1, 3, 0, 0); nop[0] = 32'h8000_0000; nop[1] = 2;
    tick;
    chk("mul_valid", out_if.valid_o, 1);
    chk("mul_wrap", out_if.res_o, 0);
    ctrl = cfg(0, 1, 4, 0, 0); nop[0] = 32'hFFFF_FFFF; nop[1] = 1;
    tick;
    chk("max_signed", out_if.res_o, 1);
    ctrl = cfg(0, 1, 5, 0, 0);
    tick;
    chk("min_signed", out_if.res_o, 32'hFFFF_FFFF);
    ctrl = cfg(0, 1, 2, 0, 0); nop[0] = 3; nop[1] = 5;
    tick;
    chk("sub_neg", out_if.res_o, 32'hFFFF_FFFE);
    ctrl = cfg(0, 1, 3, 0, 0); nop[0] = 32'hFFFF_FFFD; nop[1] = 3;
    tick;
    chk("mul_neg", out_if.res_o, 32'hFFFF_FFF7);
    ctrl = cfg(0, 1, 7, 0, 0); nop[0] = 32'h0000_1234;
    tick;
    chk("pass_a", out_if.res_o, 32'h0000_1234);
    nvld = '0;
    tick;
    chk("ops_drained", out_if.valid_o, 0);

    // asynchronous reset during an ACC window
    out_if.ready_i = 1'b0; ctrl = cfg(0, 5, 1, 0, 0); cst = 0; nop[0] = 42; nvld = 4'b0001;
    tick;
    ctrl = cfg(5, 1, 6, 0, 0); acc_len = 4; nvld = 4'b0010; nop[1] = 1;
    tick; nop[1] = 2;
    tick; nvld = '0;
    chk("pre_rst_valid", out_if.valid_o, 1);
    chk("pre_rst_res", out_if.res_o, 42);
    chk("pre_rst_dvld", dvld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_if.valid_o, 0);
    chk("arst_res", out_if.res_o, 0);
    chk("arst_dop", dop, 0);
    chk("arst_dvld", dvld, 0);
    #2 rst_n = 1'b1;
    out_if.ready_i = 1'b1;
    tick;
    nvld = 4'b0010; nop[1] = 3;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i < 3) chk("post_rst_no_push", out_if.valid_o, 0);
    end
    nvld = '0;
    chk("post_rst_res", out_if.res_o, 12);
    tick;
    chk("post_rst_drained", out_if.valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/s_pe_elastic.md
S_PE_ELASTIC -- requirements
Module: s_pe_elastic

Interface
REQ-001 Parameter N_BITS, 32, datapath width.
REQ-002 Parameter N_NEIGH, 4, number of neighbour operand inputs.
REQ-003 Parameter DELAY_DEPTH, 4, delay-line stages (power of 2, >=2).
REQ-004 Parameter OUT_DEPTH, 2, output FIFO entries (power of 2, >=2).
REQ-005 clk_i  in  1  clock; one clock domain only.
REQ-006 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 ctrl_pe_i  in  CFG_W  config word, fields LSB first: sel_a, sel_b (LOG_N_IN each), op (3), delay_src (2), delay_tap (log2 DELAY_DEPTH).
REQ-008 const_i  in  N_BITS  constant operand.
REQ-009 acc_len_i  in  16  accumulation window length; 0 is treated as 1.
REQ-010 neigh_op_i  in  N_NEIGH x N_BITS  neighbour operands.
REQ-011 neigh_valid_i  in  N_NEIGH  neighbour operand valids.
REQ-012 fire_o  in/out: out  1  operands consumed this cycle.
REQ-013 res_o  out  N_BITS  FIFO head result.
REQ-014 valid_o  out  1  FIFO non-empty.
REQ-015 ready_i  in  1  downstream accepts res_o.
REQ-016 delay_op_o  out  N_BITS  selected delay-line tap.
REQ-017 delay_valid_o  out  1  valid of selected tap.

Function
REQ-018 Operand sources: index 0..N_NEIGH-1 neighbours, N_NEIGH = SELF (last pushed result), N_NEIGH+1 = CONST; SELF and CONST always valid; LOG_N_IN = clog2(N_NEIGH+2); out-of-range selectors read as invalid.
REQ-019 op encoding: 0 NOP, 1 ADD, 2 SUB (a-b), 3 MUL (low N_BITS of signed a*b), 4 MAX, 5 MIN (signed), 6 ACC, 7 PASS_A; ADD/SUB/ACC wrap modulo 2^N_BITS.
REQ-020 fire_o = op!=NOP and both selected valids and (FIFO not full or pop this cycle); fire_o is combinational.
REQ-021 Non-ACC ops push the result into the FIFO on every fire; latency fire cycle N -> valid_o at N+1 when FIFO was empty.
REQ-022 ACC: on fire with count=0 acc<=op_b, else acc<=acc+op_b; count increments; on the fire where count==acc_len-1 push acc+op_b (or op_b if count=0), count<=0, acc<=0.
REQ-023 ACC fires that do not push require only operand valids, not FIFO space.
REQ-024 Pop when valid_o && ready_i; simultaneous push and pop on full FIFO SHALL succeed with occupancy unchanged; push on full without pop SHALL not occur.
REQ-025 SELF register updates to the pushed value on every push.
REQ-026 op change (ctrl op field differs from previous cycle) or NOP clears count and acc; FIFO contents remain and drain normally.
REQ-027 Delay line shifts on every fire, stage 0 loads source selected by delay_src (0 op_a, 1 op_b, 2 combinational FU result, 3 zero) with valid=1; no shift without fire.
REQ-028 delay_op_o/delay_valid_o = stage delay_tap (tap 0 = one fire of delay).
REQ-029 res_o SHALL read 0 whenever valid_o=0.

Reset
REQ-030 Reset clears FIFO (valid_o=0, res_o=0), SELF, acc, count, all delay stages and valids (delay_op_o=0, delay_valid_o=0).
REQ-031 Reset asserted mid-window SHALL discard the partial accumulation; first post-reset fire starts a new window.

Structure
REQ-032 pea_pkg holds s_pe_op_t, delay_src_t, and CFG_W/LOG_N_IN helper functions of N_NEIGH and DELAY_DEPTH.
REQ-033 Output buffer is sub-module s_pe_out_fifo (parameters N_BITS, OUT_DEPTH, push/pop/full/empty).

Verification
REQ-034 ADD sel_a=0, sel_b=CONST, const=5, neigh0=10 valid one cycle, ready_i=1 -> res_o=15, valid_o one cycle later.
REQ-035 ready_i=0, OUT_DEPTH=2, ADD with continuous valid -> two pushes, fire_o=0 thereafter; ready_i=1 -> pops 1st value, same-cycle fire, occupancy stays 2.
REQ-036 ACC acc_len=4, op_b = 1,2,3,4 -> exactly one push of 10 after 4th fire; acc_len=0 -> every op_b pushed directly.
REQ-037 ACC window with 2 fires, switch op to ADD then back to ACC -> partial sum discarded, next window restarts at 0.
REQ-038 delay_src=op_a, delay_tap=2, fire values 7,8,9,10 -> delay_op_o=7 after 3rd fire, delay_valid_o=1; stalls hold it.
REQ-039 MUL 0x80000000*2 -> 0; MAX -1 vs 1 -> 1; async reset mid-ACC -> all outputs 0 immediately.
